// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro used by this slice: RR_ARB_TIMEOUT_EN.
package arb_pkg;

    // Widest requester vector the index encoder handles.
    localparam int ARB_MAX_N = 32;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    // One-hot to binary by OR-ing the indices of set bits; exact for one-hot input.
    function automatic logic [4:0] onehot2bin(input logic [ARB_MAX_N-1:0] oh);
        logic [4:0] b;
        b = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) b = b | 5'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N clients and the round-robin arbiter.
// Latency: n/a (wires only).
// Backpressure: grant is held until rel, request drop or forced release.
// Ports: req/rel driven by the client side (master); grant, grant_idx,
// grant_vld and timeout driven by the arbiter (slave).
interface rr_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  req;
    logic          rel;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          grant_vld;
    logic          timeout;

    modport master (
        output req, rel,
        input  grant, grant_idx, grant_vld, timeout
    );

    modport slave (
        input  req, rel,
        output grant, grant_idx, grant_vld, timeout
    );

endinterface

// File: rtl/rr_arbiter_isolate.sv
// One-hot priority isolator: keeps only the lowest (MSB=0) or highest (MSB=1) set bit.
// Latency: combinational.
// Backpressure: none.
// Ports: in_vec (W bits) -> out_vec (W bits, one-hot or zero).
module rr_arbiter_isolate #(
    parameter int W   = 4,
    parameter bit MSB = 1'b0
) (
    input  logic [W-1:0] in_vec,
    output logic [W-1:0] out_vec
);

    generate
        if (MSB) begin : g_msb
            // Bit-reverse, isolate the lowest bit, reverse back.
            logic [W-1:0] rin;
            logic [W-1:0] rout;
            always_comb begin
                rin = '0;
                for (int i = 0; i < W; i++) rin[i] = in_vec[W-1-i];
            end
            assign rout = rin & (~rin + W'(1));
            always_comb begin
                out_vec = '0;
                for (int i = 0; i < W; i++) out_vec[i] = rout[W-1-i];
            end
        end else begin : g_lsb
            // Two's-complement trick: x & -x leaves the lowest set bit.
            assign out_vec = in_vec & (~in_vec + W'(1));
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over N requesters with registered, held grants.
// Latency: 1 cycle req -> grant; at least one IDLE cycle between grants.
// Backpressure: grant held until rel, request drop, or (RR_ARB_TIMEOUT_EN) forced release.
// Ports: clk, rst (async active-high); bus (rr_arbiter_if.slave): req, rel in;
// grant, grant_idx, grant_vld, timeout out.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_if.slave   bus
);

    localparam int IW = $clog2(N);

    arb_state_t    state;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] last_q;
    logic          timeout_q;

    logic [N-1:0]  below_last;
    logic [N-1:0]  masked;
    logic [N-1:0]  iso_masked;
    logic [N-1:0]  iso_req;
    logic [N-1:0]  win;
    logic [IW-1:0] win_idx;
    logic          expire;
    logic          release_now;

    // Bits 0..last inclusive; when last=N-1 the shift wraps to zero and the
    // mask covers everything, so the wrap-around path is taken.
    assign below_last = (N'(2) << last_q) - N'(1);
    assign masked     = bus.req & ~below_last;

    rr_arbiter_isolate #(.W(N), .MSB(1'b0)) u_iso_masked (
        .in_vec  (masked),
        .out_vec (iso_masked)
    );

    rr_arbiter_isolate #(.W(N), .MSB(1'b0)) u_iso_req (
        .in_vec  (bus.req),
        .out_vec (iso_req)
    );

    assign win     = (|masked) ? iso_masked : iso_req;
    assign win_idx = IW'(onehot2bin(ARB_MAX_N'(win)));

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;

    // cnt_q counts completed GRANT cycles; the TIMEOUT-th cycle is the last.
    assign expire = (state == ARB_GRANT) && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            // rel takes precedence: a simultaneous rel reports no timeout.
            timeout_q <= expire & ~bus.rel;
            if (state == ARB_IDLE) cnt_q <= '0;
            else                   cnt_q <= cnt_q + CW'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expire         = 1'b0;
    assign timeout_q      = 1'b0;
`endif

    assign release_now = bus.rel | ~bus.req[idx_q] | expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IW'(N - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|bus.req) begin
                        state   <= ARB_GRANT;
                        grant_q <= win;
                        idx_q   <= win_idx;
                    end
                end
                ARB_GRANT: begin
                    if (release_now) begin
                        state   <= ARB_IDLE;
                        grant_q <= '0;
                        last_q  <= idx_q;
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.grant_vld = (state == ARB_GRANT);
    assign bus.timeout   = timeout_q;

endmodule
